// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter/mux.
// State enum plus the round-robin winner search used by rr_arbiter.
package axis_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} state_e;

    // Upper bound on channel count the search helper supports.
    localparam int unsigned RR_MAX_N = 64;

    // First set bit at or after ptr, wrapping modulo n; 0 when none is set.
    function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] valid,
                                            input int unsigned         ptr,
                                            input int unsigned         n);
        int unsigned pick;
        int unsigned idx;
        pick = 0;
        for (int k = RR_MAX_N - 1; k >= 0; k--) begin
            if (unsigned'(k) < n) begin
                idx = (ptr + unsigned'(k)) % n;
                if (valid[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: returns the first requester
// at or after ptr (wrapping) and whether any request is present.
module rr_arbiter
    import axis_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_valid
);

    logic [RR_MAX_N-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        winner         = SEL_W'(rr_pick(req_ext, 32'(ptr), N));
        any_valid      = |req;
    end

endmodule

// File: rtl/axis_arb_mux.sv
// N-to-1 AXI-Stream round-robin arbiter/mux with a registered output stage.
// Define AXIS_ARB_MUX_LOCK_EN to hold the grant for a whole packet (until s_last).
module axis_arb_mux
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] s_data,
    input  logic [N-1:0]       s_valid,
    input  logic [N-1:0]       s_last,
    output logic [N-1:0]       s_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [SEL_W-1:0]   grant_id,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   lock_id_q, lock_id_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;

    logic [SEL_W-1:0]   arb_winner, sel;
    logic               arb_any, sel_any;
    logic               ld, accept;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (s_valid),
        .ptr       (rr_ptr_q),
        .winner    (arb_winner),
        .any_valid (arb_any)
    );

    // In LOCKED only the locked channel may be selected.
    always_comb begin
        sel     = arb_winner;
        sel_any = arb_any;
        if (state_q == LOCKED) begin
            sel     = lock_id_q;
            sel_any = s_valid[lock_id_q];
        end
    end

    assign ld     = !m_valid_q || m_ready;
    // rst_n gating keeps s_ready low throughout reset even though ld is high then.
    assign accept = sel_any && ld && rst_n;

    always_comb begin
        s_ready = '0;
        if (accept) s_ready[sel] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        grant_d   = grant_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        if (ld) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d = s_data[sel*WIDTH +: WIDTH];
                m_last_d = s_last[sel];
            end
        end

        if (accept) begin
            grant_d = sel;
            unique case (state_q)
                IDLE: begin
                    rr_ptr_d = (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;
`ifdef AXIS_ARB_MUX_LOCK_EN
                    if (!s_last[sel]) begin
                        state_d   = LOCKED;
                        lock_id_d = sel;
                    end
`endif
                end
                LOCKED: begin
                    if (s_last[sel]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign grant_id = grant_q;

`ifdef AXIS_ARB_MUX_LOCK_EN
    assign busy = (state_q == LOCKED);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: doc/axis_arb_mux.md
AXIS_ARB_MUX -- requirements
Module: axis_arb_mux

Interface
REQ-001 Parameter WIDTH, default 16: data width of every stream, in bits.
REQ-002 Parameter N, default 8: number of slave channels, with N>=1.
REQ-003 Parameter SEL_W, default $clog2(N) (minimum 1): width of the grant index.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 s_data  input  N*WIDTH: channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-007 s_valid  input  N: per-channel valid.
REQ-008 s_last  input  N: per-channel end-of-packet flag.
REQ-009 s_ready  output  N: per-channel ready.
REQ-010 m_data  output  WIDTH: registered output data.
REQ-011 m_valid  output  1: registered output valid.
REQ-012 m_last  output  1: registered output last flag.
REQ-013 m_ready  input  1: downstream ready.
REQ-014 grant_id  output  SEL_W: index of the channel whose beat was last accepted.
REQ-015 busy  output  1: high while the FSM is in LOCKED.

Function
REQ-016 Transfer rule: a beat transfers on a port when valid and ready are both high at a clk edge.
REQ-017 Output-register load enable: ld = !m_valid || m_ready; this gives full throughput of one beat per cycle.
REQ-018 At most one s_ready bit is high in any cycle, and it is the granted channel's bit.
- That bit equals ld.
REQ-019 An accepted beat appears on m_data/m_last with m_valid high on the next cycle, giving one cycle of latency.
REQ-020 While m_valid=1 and m_ready=0, m_data, m_last and m_valid hold stable.
REQ-021 If ld=1 and no beat is accepted, m_valid clears at the edge.
REQ-022 IDLE state, winner selection:
- Winner = first channel with s_valid=1, searching from rr_ptr upward modulo N.
- Selection is combinational in the same cycle.
- With no valid requester, no s_ready bit is asserted.
REQ-023 On any beat accepted in IDLE:
- rr_ptr <= (winner+1) mod N, wrapping from N-1 to 0.
- grant_id <= winner.
REQ-024 IDLE->LOCKED transition: the accepted beat has s_last=0, and AXIS_ARB_MUX_LOCK_EN is defined; lock_id <= winner.
REQ-025 LOCKED state:
- Only lock_id is eligible.
- Other channels' s_valid is ignored.
- rr_ptr is frozen.
REQ-026 LOCKED->IDLE transition: an accepted beat from lock_id has s_last=1.
REQ-027 In LOCKED, if s_valid[lock_id]=0, the FSM stays LOCKED and no beat is accepted.
REQ-028 Valid may change while ready is low. The grant may therefore move between cycles in IDLE when no transfer occurs.
REQ-029 N=1: the block degenerates to a registered pipeline stage and rr_ptr stays 0.

Reset
REQ-030 While rst_n=0, all of the following hold:
- m_valid=0, m_last=0, m_data=0.
- s_ready=0.
- grant_id=0, busy=0.
- rr_ptr=0, FSM=IDLE.
REQ-031 Reset asserted mid-packet discards the output register and the lock. Arbitration restarts at channel 0 after release.
REQ-032 s_ready remains 0 during reset, regardless of m_ready.

Configuration
REQ-033 With macro AXIS_ARB_MUX_LOCK_EN defined, packet locking per REQ-024 to REQ-027 is compiled in.
REQ-034 Without AXIS_ARB_MUX_LOCK_EN:
- Every beat is arbitrated independently.
- The FSM never leaves IDLE and busy is tied 0.
- s_last is still forwarded to m_last.

Structure
REQ-035 A shared package axis_pkg holds:
- The FSM state enum {IDLE, LOCKED}.
- A function rr_pick(valid vector, pointer) returning the winner index.
REQ-036 One sub-module, rr_arbiter, is used: a combinational round-robin priority encoder taking N request bits and rr_ptr, returning the winner index and an any-valid flag.

Verification
REQ-037 Scenario 1: N=4, all s_valid=1, s_last=1 on every beat, m_ready=1 -> grant sequence 0,1,2,3,0, one beat per cycle, m_valid high from cycle 1.
REQ-038 Scenario 2 (LOCK_EN): ch2 sends a 3-beat packet while ch0 and ch3 are valid -> m_data shows ch2 beats contiguously, busy=1 for beats 1 and 2, then the grant goes to ch3.
REQ-039 Scenario 3: m_ready=0 for 5 cycles with data 0xA5A5 latched -> m_data holds 0xA5A5, s_ready=0 on all channels, no data lost.
REQ-040 Scenario 4: rst_n dropped mid-packet on ch1 -> all outputs are 0 asynchronously; after release, ch1 and ch0 valid -> ch0 is granted first.
REQ-041 Scenario 5 (no LOCK_EN): ch0 and ch1 each send a 2-beat packet -> beats interleave ch0,ch1,ch0,ch1 and busy stays 0.
REQ-042 Scenario 6: only ch7 is valid, N=8, rr_ptr=7 -> ch7 is granted and rr_ptr wraps to 0.
